// File: rtl/scan_seq_74138_if.sv
// Control and decoder-side signals of the 74138 scan sequencer, grouped so the
// controlling logic and the sequencer share one bundle.
interface scan_seq_74138_if #(
  parameter int DWELL_W = 8
);
  // Handshake: start_i is a request taken only while idle (no ready; it is
  // simply ignored when busy_o=1), stop_i aborts from any state on the next
  // edge and beats start_i, done_o is a one-cycle completion pulse.
  logic               start_i;
  logic               stop_i;
  logic               mode_i;
  logic [7:0]         mask_i;
  logic [DWELL_W-1:0] dwell_i;

  logic               select_a_o;
  logic               select_b_o;
  logic               select_c_o;
  logic               g1_en_o;
  logic               g2a_en_n_o;
  logic               g2b_en_n_o;
  logic [2:0]         chan_o;
  logic               busy_o;
  logic               done_o;
  logic [1:0]         state_o;

  modport master (
    output start_i, stop_i, mode_i, mask_i, dwell_i,
    input  select_a_o, select_b_o, select_c_o,
    input  g1_en_o, g2a_en_n_o, g2b_en_n_o,
    input  chan_o, busy_o, done_o, state_o
  );

  modport slave (
    input  start_i, stop_i, mode_i, mask_i, dwell_i,
    output select_a_o, select_b_o, select_c_o,
    output g1_en_o, g2a_en_n_o, g2b_en_n_o,
    output chan_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/scan_seq_74138.sv
// Channel scan sequencer driving the select and enable pins of a 74138 decoder:
// walks the masked channels with a blanking gap and a programmable dwell.
module scan_seq_74138 #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  scan_seq_74138_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam logic [3:0] BLANK_LAST = 4'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  state_e             state_q, state_d;
  logic [2:0]         chan_q, chan_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [3:0]         blank_q, blank_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               done_evt;
  logic               load_chan;
  logic [2:0]         load_idx;
  logic [DWELL_W-1:0] load_dwell;
  logic [8:0]         upto_chan;
  logic [7:0]         above_mask;

  function automatic logic [2:0] lowest_bit(input logic [7:0] m);
    lowest_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) lowest_bit = 3'(i);
    end
  endfunction

  // Channels strictly above the current one that are still enabled this pass.
  always_comb begin
    upto_chan  = (9'd2 << chan_q) - 9'd1;
    above_mask = mask_q & ~upto_chan[7:0];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      chan_q  <= 3'd0;
      mask_q  <= 8'd0;
      dwell_q <= '0;
      cnt_q   <= '0;
      blank_q <= 4'd0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    chan_d     = chan_q;
    mask_d     = mask_q;
    dwell_d    = dwell_q;
    cnt_d      = cnt_q;
    blank_d    = blank_q;
    done_evt   = 1'b0;
    load_chan  = 1'b0;
    load_idx   = chan_q;
    load_dwell = dwell_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.mask_i != 8'd0) begin
            mask_d     = bus.mask_i;
            dwell_d    = bus.dwell_i;
            load_chan  = 1'b1;
            load_idx   = lowest_bit(bus.mask_i);
            load_dwell = bus.dwell_i;
          end else begin
            done_evt = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        if (blank_q == 4'd0) begin
          state_d = ST_DRIVE;
          cnt_d   = dwell_q;
        end else begin
          blank_d = blank_q - 4'd1;
        end
      end
      ST_DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (above_mask != 8'd0) begin
          load_chan  = 1'b1;
          load_idx   = lowest_bit(above_mask);
          load_dwell = dwell_q;
        end else if (!bus.mode_i) begin
          state_d  = ST_IDLE;
          done_evt = 1'b1;
        end else begin
          // Wrap: the next pass picks up whatever mask/dwell are presented now.
          mask_d  = bus.mask_i;
          dwell_d = bus.dwell_i;
          if (bus.mask_i == 8'd0) begin
            state_d = ST_IDLE;
          end else begin
            load_chan  = 1'b1;
            load_idx   = lowest_bit(bus.mask_i);
            load_dwell = bus.dwell_i;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_chan) begin
      chan_d = load_idx;
      if (BLANK_CYCLES == 0) begin
        state_d = ST_DRIVE;
        cnt_d   = load_dwell;
      end else begin
        state_d = ST_BLANK;
        blank_d = BLANK_LAST;
      end
    end

    // Abort overrides everything, including a same-cycle start; selects hold.
    if (bus.stop_i) begin
      state_d  = ST_IDLE;
      chan_d   = chan_q;
      done_evt = 1'b0;
    end
  end

  always_comb begin
    en_d   = (state_d == ST_DRIVE);
    busy_d = (state_d != ST_IDLE);
    done_d = done_evt;
  end

  assign bus.select_a_o = chan_q[0];
  assign bus.select_b_o = chan_q[1];
  assign bus.select_c_o = chan_q[2];
  assign bus.g1_en_o    = en_q;
  assign bus.g2a_en_n_o = ~en_q;
  assign bus.g2b_en_n_o = ~en_q;
  assign bus.chan_o     = chan_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.state_o    = state_q;

endmodule
